// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch unit:
//               FSM state encoding, NOP reset word and HALT opcode.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        WAIT   = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } state_e;

    localparam logic [15:0] c_NOP_INSTR   = 16'h0800;
    localparam logic [4:0]  c_HALT_OPCODE = 5'b00000;

    // An instruction is a HALT when its major opcode field is all zero.
    function automatic logic is_halt(input logic [15:0] word);
        return word[15:11] == c_HALT_OPCODE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_if
// Description : Fetch-unit bus: redirect/stall controls, instruction-memory
//               handshake and decode-facing outputs. The err signal exists
//               only when FETCH_ALIGN_CHK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_if;
    logic [15:0] newPC;
    logic        pcSel;
    logic        stall;
    logic [15:0] imem_addr;
    logic        imem_rd;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic [15:0] instr;
    logic [15:0] pc2;
    logic        instr_valid;
    logic        halted;
`ifdef FETCH_ALIGN_CHK_EN
    logic        err;
`endif

    modport master (
        input  newPC, pcSel, stall, imem_rdata, imem_ready,
`ifdef FETCH_ALIGN_CHK_EN
        output err,
`endif
        output imem_addr, imem_rd, instr, pc2, instr_valid, halted
    );

    modport slave (
        output newPC, pcSel, stall, imem_rdata, imem_ready,
`ifdef FETCH_ALIGN_CHK_EN
        input  err,
`endif
        input  imem_addr, imem_rd, instr, pc2, instr_valid, halted
    );
endinterface
`default_nettype wire

// File: rtl/fetch_skid.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid
// Description : One-entry skid register holding an accepted instruction and
//               its PC+2 while decode is stalled. Clear wins over load.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid
    import fetch_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        load_i,
    input  wire logic        clear_i,
    input  wire logic [15:0] instr_i,
    input  wire logic [15:0] pc2_i,
    output logic             valid_o,
    output logic [15:0]      instr_o,
    output logic [15:0]      pc2_o
);

    logic        valid_q;
    logic [15:0] instr_q;
    logic [15:0] pc2_q;

    // Capture a parked word on load, drop it on clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= c_NOP_INSTR;
            pc2_q   <= 16'h0000;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc2_q   <= pc2_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc2_o   = pc2_q;

endmodule
`default_nettype wire

// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
// Module      : fetch
// Description : 16-bit instruction fetch unit with request/ready memory
//               handshake, decode stall with one-entry skid, redirect with
//               squash of in-flight responses, and HALT detection.
//               Optional misaligned-PC trap enabled by FETCH_ALIGN_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  wire logic clk,
    input  wire logic rst,
    fetch_if.master   bus
);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc2_q, pc2_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic        squash_q, squash_d;

    logic        w_rd;
    logic        w_take;
    logic        w_pc_odd;
    logic        w_align_fault;
    logic        w_skid_load;
    logic        w_skid_clear;
    logic        w_skid_valid;
    logic [15:0] w_skid_instr;
    logic [15:0] w_skid_pc2;
    logic [15:0] w_fetch_addr;
    logic [15:0] w_next_pc;

`ifdef FETCH_ALIGN_CHK_EN
    logic err_q;

    assign w_pc_odd      = (state_q == FETCH) && pc_q[0];
    assign w_align_fault = (state_q != HALTED) && ((bus.pcSel && bus.newPC[0]) || w_pc_odd);

    // Sticky alignment error; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (w_align_fault) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign w_pc_odd      = 1'b0;
    assign w_align_fault = 1'b0;
`endif

    // WAIT keeps the issued address even after a redirect moved pc_q.
    assign w_fetch_addr  = (state_q == WAIT) ? addr_q : pc_q;
    assign w_next_pc     = w_fetch_addr + 16'd2;
    assign w_rd          = !rst && (((state_q == FETCH) && !bus.stall && !w_pc_odd) ||
                                    (state_q == WAIT));

    assign bus.imem_rd     = w_rd;
    assign bus.imem_addr   = w_fetch_addr;
    assign bus.instr       = instr_q;
    assign bus.pc2         = pc2_q;
    assign bus.instr_valid = valid_q;
    assign bus.halted      = halted_q;

    fetch_skid u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (w_skid_load),
        .clear_i (w_skid_clear),
        .instr_i (bus.imem_rdata),
        .pc2_i   (w_next_pc),
        .valid_o (w_skid_valid),
        .instr_o (w_skid_instr),
        .pc2_o   (w_skid_pc2)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            instr_q  <= c_NOP_INSTR;
            pc2_q    <= 16'h0000;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            squash_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            instr_q  <= instr_d;
            pc2_q    <= pc2_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            squash_q <= squash_d;
        end
    end

    // Next-state: halt/fault first, then redirect, then normal fetch flow.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        instr_d      = instr_q;
        pc2_d        = pc2_q;
        valid_d      = valid_q;
        halted_d     = halted_q;
        squash_d     = squash_q;
        w_take       = 1'b0;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;

        if (state_q == HALTED) begin
            valid_d  = 1'b0;
            halted_d = 1'b1;
        end else if (w_align_fault) begin
            state_d      = HALTED;
            valid_d      = 1'b0;
            halted_d     = 1'b1;
            squash_d     = 1'b0;
            w_skid_clear = 1'b1;
        end else if (bus.pcSel) begin
            pc_d         = bus.newPC;
            valid_d      = 1'b0;
            w_skid_clear = 1'b1;
            // A response still in flight must be swallowed when it arrives.
            if ((state_q == WAIT) && !bus.imem_ready) begin
                squash_d = 1'b1;
                state_d  = WAIT;
            end else begin
                squash_d = 1'b0;
                state_d  = FETCH;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (!bus.stall) begin
                        addr_d = pc_q;
                        if (bus.imem_ready) begin
                            w_take = 1'b1;
                        end else begin
                            valid_d = 1'b0;
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus.imem_ready) begin
                        if (squash_q) begin
                            squash_d = 1'b0;
                            state_d  = FETCH;
                            if (!bus.stall) valid_d = 1'b0;
                        end else begin
                            w_take = 1'b1;
                        end
                    end else if (!bus.stall) begin
                        valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!bus.stall && w_skid_valid) begin
                        instr_d      = w_skid_instr;
                        pc2_d        = w_skid_pc2;
                        valid_d      = 1'b1;
                        w_skid_clear = 1'b1;
                        state_d      = is_halt(w_skid_instr) ? HALTED : FETCH;
                    end
                end
                default: ;
            endcase

            if (w_take) begin
                pc_d = w_next_pc;
                if (bus.stall) begin
                    w_skid_load = 1'b1;
                    state_d     = HOLD;
                end else begin
                    instr_d = bus.imem_rdata;
                    pc2_d   = w_next_pc;
                    valid_d = 1'b1;
                    state_d = is_halt(bus.imem_rdata) ? HALTED : FETCH;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch
// Description : Self-checking bench for fetch: directed scenarios with
//               literal expectations plus randomized traffic checked every
//               cycle against a transaction-level model of the fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch;

    logic clk;
    logic rst;
    fetch_if bus ();

    logic [15:0] mem [0:65535];
    assign bus.imem_rdata = mem[bus.imem_addr];

    fetch #(.RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_pc: next address to fetch; m_busy/m_req: request issued, not yet
    // answered; m_discard: that answer belongs to a redirected stream;
    // m_parked: a word accepted under stall, waiting for decode;
    // m_dead: a HALT was delivered (or a fault), no more fetching.
    logic [15:0] m_pc, m_req, m_instr, m_pc2, m_pk_instr, m_pk_pc2;
    bit m_valid, m_halted, m_busy, m_discard, m_parked, m_dead, m_err;

    function automatic bit exp_rd_f();
        bit odd_block;
        odd_block = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
        odd_block = m_pc[0];
`endif
        return !rst && !m_dead && !m_parked && (m_busy || (!bus.stall && !odd_block));
    endfunction

    function automatic logic [15:0] exp_addr_f();
        return m_busy ? m_req : m_pc;
    endfunction

    task automatic m_present(input logic [15:0] w, input logic [15:0] p2);
        m_instr = w;
        m_pc2   = p2;
        m_valid = 1'b1;
        if (w[15:11] == 5'd0) m_dead = 1'b1;
    endtask

    task automatic m_step();
        bit          rd;
        logic [15:0] a;
        logic [15:0] w;
        bit          fault;
        rd    = exp_rd_f();
        a     = exp_addr_f();
        w     = mem[a];
        fault = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
        fault = !m_dead && ((bus.pcSel && bus.newPC[0]) || (!m_busy && !m_parked && m_pc[0]));
`endif
        if (m_dead) begin
            m_valid  = 1'b0;
            m_halted = 1'b1;
        end else if (fault) begin
            m_dead = 1'b1; m_halted = 1'b1; m_valid = 1'b0; m_err = 1'b1;
            m_parked = 1'b0; m_busy = 1'b0; m_discard = 1'b0;
        end else if (bus.pcSel) begin
            m_pc     = bus.newPC;
            m_valid  = 1'b0;
            m_parked = 1'b0;
            if (m_busy && !bus.imem_ready) m_discard = 1'b1;
            else begin m_busy = 1'b0; m_discard = 1'b0; end
        end else if (m_parked) begin
            if (!bus.stall) begin
                m_parked = 1'b0;
                m_present(m_pk_instr, m_pk_pc2);
            end
        end else if (rd && bus.imem_ready) begin
            m_busy = 1'b0;
            if (m_discard) begin
                m_discard = 1'b0;
                if (!bus.stall) m_valid = 1'b0;
            end else begin
                m_pc = a + 16'd2;
                if (bus.stall) begin
                    m_parked = 1'b1; m_pk_instr = w; m_pk_pc2 = a + 16'd2;
                end else begin
                    m_present(w, a + 16'd2);
                end
            end
        end else if (rd) begin
            m_busy = 1'b1;
            m_req  = a;
            if (!bus.stall) m_valid = 1'b0;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = 16'h0000; m_req = 16'h0000; m_instr = 16'h0800; m_pc2 = 16'h0000;
            m_pk_instr = 16'h0800; m_pk_pc2 = 16'h0000;
            m_valid = 0; m_halted = 0; m_busy = 0; m_discard = 0; m_parked = 0;
            m_dead = 0; m_err = 0;
        end else begin
            m_step();
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        #1;
        if (cmp_en) begin
            chk("instr", bus.instr, m_instr);
            chk("pc2", bus.pc2, m_pc2);
            chk("instr_valid", 16'(bus.instr_valid), 16'(m_valid));
            chk("halted", 16'(bus.halted), 16'(m_halted));
            chk("imem_rd", 16'(bus.imem_rd), 16'(exp_rd_f()));
            if (exp_rd_f()) chk("imem_addr", bus.imem_addr, exp_addr_f());
`ifdef FETCH_ALIGN_CHK_EN
            chk("err", 16'(bus.err), 16'(m_err));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit s, input bit p, input logic [15:0] np, input bit r);
        @(negedge clk);
        rst            = 1'b0;
        bus.stall      = s;
        bus.pcSel      = p;
        bus.newPC      = np;
        bus.imem_ready = r;
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        bus.stall      = 1'b0;
        bus.pcSel      = 1'b0;
        bus.newPC      = 16'h0000;
        bus.imem_ready = 1'b0;
        #2;
        chk("rst_instr", bus.instr, 16'h0800);
        chk("rst_pc2", bus.pc2, 16'h0000);
        chk("rst_valid", 16'(bus.instr_valid), 16'd0);
        chk("rst_halted", 16'(bus.halted), 16'd0);
        chk("rst_rd", 16'(bus.imem_rd), 16'd0);
    endtask

    initial begin
        logic [15:0] np;
        rst = 1'b1;
        bus.stall = 1'b0; bus.pcSel = 1'b0; bus.newPC = 16'h0000; bus.imem_ready = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = {5'($urandom_range(1, 31)), 11'($urandom)};
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;

        // Zero-wait memory: one instruction per cycle.
        do_reset();
        drive(0, 0, 16'h0000, 1);
        chk("zw_addr0", bus.imem_addr, 16'h0000);
        for (int k = 1; k <= 3; k++) begin
            drive(0, 0, 16'h0000, 1);
            chk("zw_valid", 16'(bus.instr_valid), 16'd1);
            chk("zw_pc2", bus.pc2, 16'(2 * k));
            chk("zw_instr", bus.instr, mem[2 * k - 2]);
        end

        // Ready delayed three cycles.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 16'h0000, k == 3);
            chk("dly_addr", bus.imem_addr, 16'h0000);
            chk("dly_rd", 16'(bus.imem_rd), 16'd1);
            if (k > 0) chk("dly_bubble", 16'(bus.instr_valid), 16'd0);
        end
        drive(0, 0, 16'h0000, 0);
        chk("dly_valid", 16'(bus.instr_valid), 16'd1);
        chk("dly_pc2", bus.pc2, 16'h0002);
        chk("dly_instr", bus.instr, mem[0]);

        // Stall arriving with the response: parked, then released.
        do_reset();
        drive(0, 0, 16'h0000, 0);
        drive(1, 0, 16'h0000, 1);
        drive(1, 0, 16'h0000, 0);
        chk("skid_frozen_v", 16'(bus.instr_valid), 16'd0);
        chk("skid_rd", 16'(bus.imem_rd), 16'd0);
        drive(0, 0, 16'h0000, 0);
        chk("skid_frozen_v2", 16'(bus.instr_valid), 16'd0);
        drive(0, 0, 16'h0000, 1);
        chk("skid_valid", 16'(bus.instr_valid), 16'd1);
        chk("skid_pc2", bus.pc2, 16'h0002);
        chk("skid_instr", bus.instr, mem[0]);
        chk("skid_next_addr", bus.imem_addr, 16'h0002);
        drive(0, 0, 16'h0000, 0);
        chk("skid_next_pc2", bus.pc2, 16'h0004);

        // Redirect during WAIT.
        do_reset();
        drive(0, 0, 16'h0000, 0);
        drive(0, 1, 16'h0040, 0);
        drive(0, 0, 16'h0000, 1);
        chk("sq_old_addr", bus.imem_addr, 16'h0000);
        drive(0, 0, 16'h0000, 0);
        chk("sq_new_addr", bus.imem_addr, 16'h0040);
        chk("sq_discard", 16'(bus.instr_valid), 16'd0);
        drive(0, 0, 16'h0000, 1);
        drive(0, 0, 16'h0000, 0);
        chk("sq_valid", 16'(bus.instr_valid), 16'd1);
        chk("sq_pc2", bus.pc2, 16'h0042);

        // PC wrap at the top of memory.
        do_reset();
        drive(0, 1, 16'hFFFE, 0);
        drive(0, 0, 16'h0000, 1);
        chk("wrap_addr", bus.imem_addr, 16'hFFFE);
        drive(0, 0, 16'h0000, 0);
        chk("wrap_pc2", bus.pc2, 16'h0000);
        chk("wrap_next_addr", bus.imem_addr, 16'h0000);

        // HALT at 0x000A.
        mem[16'h000A] = 16'h0000;
        do_reset();
        repeat (6) drive(0, 0, 16'h0000, 1);
        drive(0, 0, 16'h0000, 1);
        chk("halt_valid", 16'(bus.instr_valid), 16'd1);
        chk("halt_instr", bus.instr, 16'h0000);
        chk("halt_pc2", bus.pc2, 16'h000C);
        chk("halt_rd", 16'(bus.imem_rd), 16'd0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 16'h0000, 1);
            chk("halted", 16'(bus.halted), 16'd1);
            chk("halted_valid", 16'(bus.instr_valid), 16'd0);
            chk("halted_rd", 16'(bus.imem_rd), 16'd0);
        end
        mem[16'h000A] = 16'h1234;

        // Randomized traffic with a couple of HALTs in the low program area.
        mem[16'h0060] = 16'h0000;
        mem[16'h00B4] = 16'h07FF;
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 3) == 0) np = 16'hFFF8 + 16'($urandom_range(0, 3) * 2);
                else np = 16'($urandom) & 16'hFFFE;
                drive($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, np,
                      $urandom_range(0, 1) == 1);
            end
        end

        @(negedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
